// File: rtl/conditional_logic_pkg.sv
// conditional_logic_pkg
//   Shared constants for the condition-evaluation stage of the control unit:
//   condition-code encodings, NZCV bit positions, instruction class codes and
//   a helper that evaluates a condition code against a flag set.
package conditional_logic_pkg;

  // Condition codes (3-bit Cond field)
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_GT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LT = 3'b101;
  localparam logic [2:0] COND_LE = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  // Bit positions inside the 4-bit {N,Z,C,V} flag word
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Instruction classes carried on op (informational only)
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b11;

  // Returns 1 when an instruction with condition code cond executes under
  // the given flag word.
  function automatic logic cond_eval(input logic [2:0] cond,
                                     input logic [3:0] flags);
    logic n, z, v;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    case (cond)
      COND_AL: cond_eval = 1'b1;
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_GT: cond_eval = ~z & (n == v);
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_LE: cond_eval = z | (n != v);
      COND_NV: cond_eval = 1'b0;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/conditional_logic_cond_check.sv
// cond_check
//   Purely combinational condition evaluator.
//   Ports:
//     cond    in  3  condition code of the executing instruction
//     flags   in  4  stored {N,Z,C,V}
//     cond_ex out 1  1 when the instruction is allowed to execute
module cond_check
  import conditional_logic_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  // C is not consulted by any of the supported condition codes.
  logic unused_carry;
  assign unused_carry = flags[FLAG_C];

  always_comb begin
    cond_ex = 1'b0;
    cond_ex = cond_eval(cond, flags);
  end

endmodule

// File: rtl/conditional_logic.sv
// conditional_logic
//   Condition-evaluation and write-gating stage between the main decoder and
//   the datapath. Holds the NZCV flag register, evaluates the condition code
//   against the stored flags, and suppresses PC/register/memory writes (and
//   the instruction's own flag update) when the condition fails.
//   Ports:
//     clk       in  1  rising-edge clock
//     reset     in  1  synchronous active-high, clears flags
//     op        in  2  instruction class, informational only
//     Cond      in  3  condition code
//     ALUFlags  in  4  {N,Z,C,V} from the ALU
//     FlagW     in  2  [1] write N,Z  [0] write C,V
//     PCS       in  1  instruction writes PC
//     RegW      in  1  instruction writes register file
//     MemW      in  1  instruction writes memory
//     NoWrite   in  1  suppress register write (compare ops)
//     PCSrc     out 1  gated PC-write select
//     RegWrite  out 1  gated register write enable
//     MemWrite  out 1  gated memory write enable
module conditional_logic
  import conditional_logic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [2:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite
);

  logic [3:0] flags;
  logic       cond_ex;
  logic [1:0] flag_wr;

  // op is carried for visibility only; it never reaches the outputs.
  logic unused_op;
  assign unused_op = ^op;

  // Conditions are evaluated on the registered flags, never on ALUFlags,
  // so a following instruction sees new flags only after the clock edge.
  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  // A failing condition also blocks the instruction's own flag update.
  assign flag_wr = FlagW & {2{cond_ex}};

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else begin
      if (flag_wr[1]) begin
        flags[FLAG_N] <= ALUFlags[FLAG_N];
        flags[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (flag_wr[0]) begin
        flags[FLAG_C] <= ALUFlags[FLAG_C];
        flags[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  always_comb begin
    PCSrc    = PCS & cond_ex;
    RegWrite = RegW & cond_ex & ~NoWrite;
    MemWrite = MemW & cond_ex;
  end

endmodule

// File: tb/tb_conditional_logic.sv
module tb_conditional_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [2:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       PCSrc, RegWrite, MemWrite;

  int vectors = 0;
  int miscompares = 0;

  conditional_logic dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs then change 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-written condition table from the ISA definition.
  function automatic logic exp_cond(input logic [2:0] c, input logic [3:0] f);
    logic n, z, v;
    n = f[3]; z = f[2]; v = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return !z && (n == v);
      3'd4: return n == v;
      3'd5: return n != v;
      3'd6: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    // Reset with a simultaneous flag write request: reset must win.
    reset = 1'b1; op = 2'b00; Cond = 3'b000; ALUFlags = 4'b1111; FlagW = 2'b11;
    PCS = 1'b0; RegW = 1'b1; MemW = 1'b0; NoWrite = 1'b0;
    tick();
    chk("reset_flags", dut.flags, 4'b0000);
    reset = 1'b0; FlagW = 2'b00; ALUFlags = 4'b0000;
    #1;
    chk("al_regwrite", {3'b0, RegWrite}, 4'b0001);
    chk("al_pcsrc", {3'b0, PCSrc}, 4'b0000);
    tick();
    chk("al_flags_hold", dut.flags, 4'b0000);

    // CMP setting C, then BGT taken.
    Cond = 3'b000; FlagW = 2'b11; NoWrite = 1'b1; RegW = 1'b1; ALUFlags = 4'b0010;
    #1;
    chk("cmp_regwrite", {3'b0, RegWrite}, 4'b0000);
    tick();
    chk("cmp_flags", dut.flags, 4'b0010);
    Cond = 3'b011; PCS = 1'b1; FlagW = 2'b00; NoWrite = 1'b0; RegW = 1'b0; op = 2'b11;
    #1;
    chk("bgt_taken", {3'b0, PCSrc}, 4'b0001);

    // BLT not taken with the same flags.
    Cond = 3'b101;
    #1;
    chk("blt_not_taken", {3'b0, PCSrc}, 4'b0000);
    tick();
    chk("blt_flags_hold", dut.flags, 4'b0010);

    // Partial write: only N,Z updated.
    PCS = 1'b0; op = 2'b00; Cond = 3'b000; FlagW = 2'b10; ALUFlags = 4'b1101;
    tick();
    chk("partial_nz", dut.flags, 4'b1110);
    FlagW = 2'b00; Cond = 3'b101; PCS = 1'b1;
    #1;
    chk("partial_lt", {3'b0, PCSrc}, 4'b0001);

    // Partial write: only C,V updated.
    PCS = 1'b0; Cond = 3'b000; FlagW = 2'b01; ALUFlags = 4'b0001;
    tick();
    chk("partial_cv", dut.flags, 4'b1101);

    // Failed condition blocks writes and its own flag update.
    Cond = 3'b000; FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    chk("load_z", dut.flags, 4'b0100);
    Cond = 3'b010; FlagW = 2'b11; RegW = 1'b1; MemW = 1'b1; ALUFlags = 4'b1001;
    #1;
    chk("ne_fail_regwrite", {3'b0, RegWrite}, 4'b0000);
    chk("ne_fail_memwrite", {3'b0, MemWrite}, 4'b0000);
    tick();
    chk("ne_fail_flags", dut.flags, 4'b0100);

    // Unknown op has no effect on outputs.
    Cond = 3'b001; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0; FlagW = 2'b00;
    op = 2'bxx;
    #1;
    chk("opx_outputs", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0111);
    op = 2'b01;

    // Exhaustive sweep: load each flag value, then evaluate all 8 codes.
    for (int f = 0; f < 16; f++) begin
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
      Cond = 3'b000; FlagW = 2'b11; ALUFlags = 4'(f);
      tick();
      chk($sformatf("sweep_load_%0d", f), dut.flags, 4'(f));
      FlagW = 2'b00; ALUFlags = ~4'(f);
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0;
      for (int c = 0; c < 8; c++) begin
        logic e;
        Cond = 3'(c);
        #1;
        e = exp_cond(3'(c), 4'(f));
        chk($sformatf("sweep_f%0d_c%0d", f, c),
            {1'b0, PCSrc, RegWrite, MemWrite}, {1'b0, e, e, e});
      end
    end

    // NoWrite masks only the register write.
    Cond = 3'b000; NoWrite = 1'b1;
    #1;
    chk("nowrite_mask", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0101);

    // Reset mid-run clears nonzero flags despite a pending write.
    reset = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1010; NoWrite = 1'b0;
    tick();
    chk("midrun_reset", dut.flags, 4'b0000);
    reset = 1'b0; FlagW = 2'b00; Cond = 3'b001;
    #1;
    chk("post_reset_eq", {3'b0, PCSrc}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conditional_logic.md
Name: conditional_logic

Overview:
Condition-evaluation and write-gating stage of the processor control unit.
- Holds the architectural NZCV flag register.
- Evaluates the instruction's 3-bit condition code against the stored flags.
- Suppresses the PC, register-file and memory write enables when the condition fails.
- Sits between the main decoder (PCS/RegW/MemW/FlagW/NoWrite) and the datapath.

Parameters:
- none: widths are fixed by the ISA (Cond 3 bits, flags 4 bits).

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high; clears flag register
op  in  2  instruction class (00 data-processing, 01 memory, 11 branch); informational only, no effect on outputs
Cond  in  3  condition code of executing instruction
ALUFlags  in  4  NZCV from ALU: [3]=N [2]=Z [1]=C [0]=V
FlagW  in  2  flag write request: [1] updates N,Z; [0] updates C,V
PCS  in  1  decoder: instruction writes PC (branch)
RegW  in  1  decoder: instruction writes register file
MemW  in  1  decoder: instruction writes memory
NoWrite  in  1  decoder: suppress register write (compare-type ops)
PCSrc  out  1  gated PC-write select
RegWrite  out  1  gated register-file write enable
MemWrite  out  1  gated memory write enable

Behaviour:
- One clock, synchronous active-high reset.
- Flag register Flags[3:0] = {N,Z,C,V}; reset value 4'b0000.
- Condition decode (CondEx), evaluated combinationally on the stored Flags, not on ALUFlags:
  - 000 AL: 1
  - 001 EQ: Z
  - 010 NE: ~Z
  - 011 GT: ~Z & (N==V)
  - 100 GE: N==V
  - 101 LT: N!=V
  - 110 LE: Z | (N!=V)
  - 111 NV: 0 (reserved; instruction never executes)
- Flag update on rising clk when reset=0:
  - Flags[3:2] <= ALUFlags[3:2] iff FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] iff FlagW[0] & CondEx.
  - Fields not selected hold their value.
- Outputs are purely combinational, with no latency beyond the flag register:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & ~NoWrite
  - MemWrite = MemW & CondEx
- Outputs during reset follow the same equations. While reset=1 on a clock edge, the flags load 0000 with no update, so condition evaluation after reset sees all-zero flags.
- Reset has priority over any simultaneous flag write.
- A flag-setting instruction followed directly by a conditional instruction:
  - The conditional instruction sees the new flags only after the intervening rising edge.
  - No combinational forwarding of ALUFlags.
- A failed condition also blocks its own flag update.
- X/unknown op has no effect on outputs.

Decomposition:
- Shared control package:
  - Cond encoding constants (COND_AL … COND_NV).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - op class constants.
- One sub-module, cond_check: a purely combinational Cond + Flags -> CondEx evaluator.
- Top level holds the flag register and output gating.

Test Plan:
- Reset then AL data op: reset=1 one edge; Cond=000, RegW=1, NoWrite=0 -> RegWrite=1; Flags=0000.
- CMP then BGT taken:
  - Cond=000, FlagW=11, NoWrite=1, RegW=1, ALUFlags=0010, clock edge -> Flags=0010 and RegWrite=0.
  - Then Cond=011, PCS=1, FlagW=00 -> PCSrc=1.
- Same flags (0010), BLT not taken: Cond=101, PCS=1 -> PCSrc=0; Flags unchanged.
- Partial flag write:
  - Start from Flags=0010; FlagW=10, ALUFlags=1101, edge -> Flags=1110.
  - Then Cond=101 (LT, N=1, V=0) -> CondEx=1.
- Failed condition blocks effects:
  - Flags=0100 (Z=1), Cond=010 (NE), FlagW=11, RegW=1, MemW=1, ALUFlags=1001.
  - Expect RegWrite=0, MemWrite=0; after edge Flags still 0100.
- Exhaustive condition sweep:
  - All 16 flag values × 8 Cond codes, with PCS=RegW=MemW=1 and NoWrite=0.
  - Check all three outputs against the table.
  - NV always 0; EQ vs NE complementary; LE = ~GT; LT = ~GE.
